ttd_wta: RTL

Winner-take-all decoder placed directly downstream of the `ttd` time-to-decision stage. On `ttd`'s `finish` pulse it snapshots the per-neuron first-spike latencies. It then scans them one neuron per cycle and reports the earliest-firing neuron as the class decision, with tie and no-spike flags. A valid/ready handshake delivers the result to the consumer.

---
 rtl/ttd_wta.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ttd_wta.sv
// Winner-take-all decoder: snapshots ttd latencies on ttd_finish and reports the earliest neuron.
// Latency: valid is sampled high at the (N_NEURONS+1)th edge after ttd_finish is sampled.
// Backpressure: the result is held in HOLD until valid && ready; finish while busy only pulses overrun.
module ttd_wta #(
    parameter int TTD_WIDTH = 5,
    parameter int N_NEURONS = 4,
    parameter int IDX_WIDTH = $clog2(N_NEURONS)
) (
    input  logic                 CLK,
    input  logic                 nRES,
    input  logic                 ttd_finish,
    input  logic [TTD_WIDTH-1:0] ttd_vectors [N_NEURONS],
    input  logic                 ready,
    output logic                 valid,
    output logic [IDX_WIDTH-1:0] class_idx,
    output logic [TTD_WIDTH-1:0] class_time,
    output logic                 no_spike,
    output logic                 tie,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    localparam logic [TTD_WIDTH-1:0] NEVER  = '1;
    localparam logic [IDX_WIDTH-1:0] LAST_K = IDX_WIDTH'(N_NEURONS - 1);

    state_t               state, state_n;
    logic [TTD_WIDTH-1:0] snap [N_NEURONS];
    logic [IDX_WIDTH-1:0] k, k_n;
    logic [TTD_WIDTH-1:0] best_time, best_time_n;
    logic [IDX_WIDTH-1:0] best_idx, best_idx_n;
    logic                 best_tie, best_tie_n;
    logic [TTD_WIDTH-1:0] cur;
    logic                 load_snap;
    logic                 load_out;
    logic                 accept;

    always_comb begin
        state_n     = state;
        k_n         = k;
        best_time_n = best_time;
        best_idx_n  = best_idx;
        best_tie_n  = best_tie;
        load_snap   = 1'b0;
        load_out    = 1'b0;
        accept      = 1'b0;
        cur         = snap[k];
        case (state)
            IDLE: begin
                if (ttd_finish) begin
                    load_snap   = 1'b1;
                    best_time_n = NEVER;
                    best_idx_n  = '0;
                    best_tie_n  = 1'b0;
                    k_n         = '0;
                    state_n     = SCAN;
                end
            end
            SCAN: begin
                // Equal latency never moves best_idx, so the lowest index wins ties.
                if (cur < best_time) begin
                    best_time_n = cur;
                    best_idx_n  = k;
                    best_tie_n  = 1'b0;
                end else if ((cur == best_time) && (best_time != NEVER)) begin
                    best_tie_n = 1'b1;
                end
                if (k == LAST_K) begin
                    state_n  = HOLD;
                    load_out = 1'b1;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            HOLD: begin
                if (valid && ready) begin
                    accept  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRES) begin
            state      <= IDLE;
            k          <= '0;
            best_time  <= '0;
            best_idx   <= '0;
            best_tie   <= 1'b0;
            valid      <= 1'b0;
            class_idx  <= '0;
            class_time <= '0;
            no_spike   <= 1'b0;
            tie        <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) snap[i] <= '0;
        end else begin
            state     <= state_n;
            k         <= k_n;
            best_time <= best_time_n;
            best_idx  <= best_idx_n;
            best_tie  <= best_tie_n;
            busy      <= (state_n != IDLE);
            overrun   <= ttd_finish && (state != IDLE);
            if (load_snap) begin
                for (int i = 0; i < N_NEURONS; i++) snap[i] <= ttd_vectors[i];
            end
            // Result registers load with the last comparison and stay frozen through HOLD.
            if (load_out) begin
                valid      <= 1'b1;
                class_idx  <= best_idx_n;
                class_time <= best_time_n;
                tie        <= best_tie_n;
                no_spike   <= (best_time_n == NEVER);
            end else if (accept) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
